// File: rtl/icu_wide.sv
// ---------------------------------------------------------------------------
// icu_wide
// Clocked, WIDTH-lane successor of the MC14500B industrial control unit.
// Executes the 16-opcode instruction_t set on a bitwise datapath with
// per-lane input/output enables. It owns its program counter and a
// hardware return stack, so JMP/RTN are resolved internally.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   pc             address of the instruction expected on instr_*
//   instr_valid    instr_op / instr_target / data_in valid for pc
//   instr_ready    instruction accepted this cycle (low only while a
//                  store beat is blocked by the sink)
//   instr_op       opcode (instruction_t)
//   instr_target   JMP destination
//   data_in        operand, sampled with the accepted instruction
//   out_valid      store beat pending
//   out_ready      sink accepts the store beat
//   data_out       stored value
//   write_en       per-lane write strobe of the pending beat
//   rr_out         result register
//   flag_o/flag_f  one-cycle pulse on an executed NOPO / NOPF
//   err_ovf/unf    sticky return-stack overflow / underflow
// ---------------------------------------------------------------------------
package instructions;
   typedef enum logic [3:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } instruction_t;
endpackage

module icu_wide
   import instructions::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pc,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  instruction_t      instr_op,
   input  logic [ADDR_W-1:0] instr_target,
   input  logic [WIDTH-1:0]  data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  data_out,
   output logic [WIDTH-1:0]  write_en,
   output logic [WIDTH-1:0]  rr_out,
   output logic              flag_o,
   output logic              flag_f,
   output logic              err_ovf,
   output logic              err_unf
);

   // Stack pointer counts occupied entries: 0 (empty) .. STACK_DEPTH (full).
   localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

   logic [WIDTH-1:0]  rr;
   logic [WIDTH-1:0]  ien;
   logic [WIDTH-1:0]  oen;
   logic              skip;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   logic [WIDTH-1:0]  mask;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stack_top;
   logic              stack_full;
   logic              stack_empty;
   logic              accept;
   logic              exec;
   logic              push;
   logic              pop;

   assign rr_out = rr;

   always_comb begin
      instr_ready = ~(out_valid & ~out_ready);
      accept      = instr_valid & instr_ready;
      exec        = accept & ~skip;
      mask        = data_in & ien;
      pc_inc      = pc + ADDR_W'(1);
      stack_full  = (sp == SP_W'(STACK_DEPTH));
      stack_empty = (sp == '0);
      push        = exec & (instr_op == JMP) & ~stack_full;
      pop         = exec & (instr_op == RTN) & ~stack_empty;
      // Loop mux keeps the array index free of pointer-width mismatches
      // for any STACK_DEPTH.
      stack_top   = '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
         if (sp == SP_W'(i + 1)) stack_top = stack_mem[i];
      end
   end

   // Return-address storage; contents are meaningless until pushed, so
   // no reset is needed here.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
         if (push && sp == SP_W'(i)) stack_mem[i] <= pc_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= '0;
         rr        <= '0;
         ien       <= '0;
         oen       <= '0;
         skip      <= 1'b0;
         sp        <= '0;
         data_out  <= '0;
         write_en  <= '0;
         out_valid <= 1'b0;
         flag_o    <= 1'b0;
         flag_f    <= 1'b0;
         err_ovf   <= 1'b0;
         err_unf   <= 1'b0;
      end else begin
         flag_o <= 1'b0;
         flag_f <= 1'b0;

         // Completion first; a store accepted in the same cycle overrides it
         // below so back-to-back beats keep out_valid high.
         if (out_valid && out_ready) out_valid <= 1'b0;

         if (accept) begin
            if (skip) begin
               skip <= 1'b0;
               pc   <= pc_inc;
            end else begin
               pc <= pc_inc;
               case (instr_op)
                  LD:   rr <= mask;
                  LDC:  rr <= ~mask;
                  AND:  rr <= rr & mask;
                  ANDC: rr <= rr & ~mask;
                  OR:   rr <= rr | mask;
                  ORC:  rr <= rr | ~mask;
                  XNOR: rr <= rr ^ ~mask;
                  IEN:  ien <= data_in;
                  OEN:  oen <= mask;
                  STO, STOC: begin
                     data_out <= (instr_op == STO) ? rr : ~rr;
                     write_en <= oen;
                     if (oen != '0) out_valid <= 1'b1;
                  end
                  SKZ:  skip <= (rr == '0);
                  NOPO: flag_o <= 1'b1;
                  NOPF: flag_f <= 1'b1;
                  JMP: begin
                     pc <= instr_target;
                     if (push) sp <= sp + SP_W'(1);
                     else      err_ovf <= 1'b1;
                  end
                  RTN: begin
                     if (pop) begin
                        pc   <= stack_top;
                        sp   <= sp - SP_W'(1);
                        skip <= 1'b1;
                     end else begin
                        err_unf <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_icu_wide.sv
// ---------------------------------------------------------------------------
// tb_icu_wide
// Directed bench for icu_wide: a table of single-instruction vectors for
// the datapath, followed by hand-written sequences for store back-pressure,
// jump/return, stack overflow/underflow, pc wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_icu_wide;
   import instructions::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   pc;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   instruction_t instr_op = NOPO;
   logic [7:0]   instr_target = '0;
   logic [7:0]   data_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [7:0]   data_out;
   logic [7:0]   write_en;
   logic [7:0]   rr_out;
   logic         flag_o, flag_f, err_ovf, err_unf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   icu_wide #(.WIDTH(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_target(instr_target), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .write_en(write_en), .rr_out(rr_out),
      .flag_o(flag_o), .flag_f(flag_f), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   typedef struct {
      instruction_t op;
      logic [7:0]   din;
      logic [7:0]   exp_rr;
      logic [7:0]   exp_pc;
      logic         exp_fo;
      logic         exp_ff;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present one instruction for exactly one edge; returns #1 after the edge.
   task automatic issue(input instruction_t op, input logic [7:0] tgt, input logic [7:0] din);
      instr_valid  = 1'b1;
      instr_op     = op;
      instr_target = tgt;
      data_in      = din;
      @(posedge clk);
      #1;
      instr_valid  = 1'b0;
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rets [4];

   initial begin
      //            op    din    rr     pc     fo    ff
      vecs[0]  = '{IEN,  8'h0F, 8'h00, 8'd1,  1'b0, 1'b0};
      vecs[1]  = '{LD,   8'hFF, 8'h0F, 8'd2,  1'b0, 1'b0};
      vecs[2]  = '{OR,   8'h30, 8'h0F, 8'd3,  1'b0, 1'b0};
      vecs[3]  = '{XNOR, 8'hF0, 8'hF0, 8'd4,  1'b0, 1'b0};
      vecs[4]  = '{IEN,  8'hFF, 8'hF0, 8'd5,  1'b0, 1'b0};
      vecs[5]  = '{LD,   8'h00, 8'h00, 8'd6,  1'b0, 1'b0};
      vecs[6]  = '{SKZ,  8'h00, 8'h00, 8'd7,  1'b0, 1'b0};
      vecs[7]  = '{LD,   8'hFF, 8'h00, 8'd8,  1'b0, 1'b0};
      vecs[8]  = '{OR,   8'h01, 8'h01, 8'd9,  1'b0, 1'b0};
      vecs[9]  = '{LDC,  8'h0F, 8'hF0, 8'd10, 1'b0, 1'b0};
      vecs[10] = '{AND,  8'h3C, 8'h30, 8'd11, 1'b0, 1'b0};
      vecs[11] = '{ANDC, 8'h10, 8'h20, 8'd12, 1'b0, 1'b0};
      vecs[12] = '{ORC,  8'hFE, 8'h21, 8'd13, 1'b0, 1'b0};
      vecs[13] = '{XNOR, 8'h21, 8'hFF, 8'd14, 1'b0, 1'b0};
      vecs[14] = '{SKZ,  8'h00, 8'hFF, 8'd15, 1'b0, 1'b0};
      vecs[15] = '{LD,   8'h00, 8'h00, 8'd16, 1'b0, 1'b0};
      vecs[16] = '{NOPO, 8'h00, 8'h00, 8'd17, 1'b1, 1'b0};
      vecs[17] = '{NOPF, 8'h00, 8'h00, 8'd18, 1'b0, 1'b1};
      vecs[18] = '{LD,   8'h00, 8'h00, 8'd19, 1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst_pc", pc, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rr", rr_out, 0);
      chk("rst_errs", {err_ovf, err_unf, flag_o, flag_f}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Datapath table
      for (int i = 0; i < 19; i++) begin
         issue(vecs[i].op, 8'h00, vecs[i].din);
         chk($sformatf("vec%0d_rr", i), rr_out, vecs[i].exp_rr);
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_flag_o", i), flag_o, vecs[i].exp_fo);
         chk($sformatf("vec%0d_flag_f", i), flag_f, vecs[i].exp_ff);
      end

      // Store with back-pressure, then a store overlapping completion
      issue(OEN, 8'h00, 8'h81);
      issue(LD, 8'h00, 8'h5A);
      out_ready = 1'b0;
      issue(STO, 8'h00, 8'h00);
      chk("sto_valid", out_valid, 1);
      chk("sto_ready_low", instr_ready, 0);
      instr_valid = 1'b1;
      instr_op    = STOC;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d_valid", c), out_valid, 1);
         chk($sformatf("stall%0d_data", c), data_out, 8'h5A);
         chk($sformatf("stall%0d_we", c), write_en, 8'h81);
         chk($sformatf("stall%0d_pc", c), pc, 8'd22);
         chk($sformatf("stall%0d_ready", c), instr_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("release_ready", instr_ready, 1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      chk("stoc_valid", out_valid, 1);
      chk("stoc_data", data_out, 8'hA5);
      chk("stoc_pc", pc, 8'd23);
      @(posedge clk);
      #1;
      chk("beat_done", out_valid, 0);

      // Jump / return with legacy skip
      do_reset();
      issue(JMP, 8'h10, 8'h00);
      chk("jmp_pc10", pc, 8'h10);
      issue(JMP, 8'h40, 8'h00);
      chk("jmp_pc40", pc, 8'h40);
      issue(RTN, 8'h00, 8'h00);
      chk("rtn_pc11", pc, 8'h11);
      issue(LDC, 8'h00, 8'h00);
      chk("rtn_skip_pc", pc, 8'h12);
      chk("rtn_skip_rr", rr_out, 8'h00);
      issue(RTN, 8'h00, 8'h00);
      chk("rtn_pc01", pc, 8'h01);
      issue(NOPO, 8'h00, 8'h00);
      chk("rtn2_skip_pc", pc, 8'h02);
      chk("rtn2_skip_flag", flag_o, 0);
      chk("no_err", {err_ovf, err_unf}, 0);

      // Overflow on the fifth nested call, underflow on the fifth return
      do_reset();
      issue(JMP, 8'h10, 8'h00);
      issue(JMP, 8'h20, 8'h00);
      issue(JMP, 8'h30, 8'h00);
      issue(JMP, 8'h40, 8'h00);
      chk("full_no_ovf", err_ovf, 0);
      issue(JMP, 8'h50, 8'h00);
      chk("ovf_pc", pc, 8'h50);
      chk("ovf_set", err_ovf, 1);
      rets[0] = 8'h31; rets[1] = 8'h21; rets[2] = 8'h11; rets[3] = 8'h01;
      for (int r = 0; r < 4; r++) begin
         issue(RTN, 8'h00, 8'h00);
         chk($sformatf("pop%0d_pc", r), pc, rets[r]);
         issue(NOPO, 8'h00, 8'h00);
         chk($sformatf("pop%0d_skip_pc", r), pc, rets[r] + 8'd1);
         chk($sformatf("pop%0d_skip_flag", r), flag_o, 0);
      end
      chk("no_unf_yet", err_unf, 0);
      issue(RTN, 8'h00, 8'h00);
      chk("unf_set", err_unf, 1);
      chk("unf_pc", pc, 8'h03);
      issue(LDC, 8'h00, 8'h00);
      chk("unf_noskip_rr", rr_out, 8'hFF);
      chk("unf_noskip_pc", pc, 8'h04);
      chk("ovf_sticky", err_ovf, 1);

      // Asynchronous reset in the middle of a blocked store
      out_ready = 1'b0;
      issue(IEN, 8'h00, 8'hFF);
      issue(OEN, 8'h00, 8'hFF);
      issue(STO, 8'h00, 8'h00);
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_pc", pc, 0);
      chk("async_rst_we", write_en, 0);
      chk("async_rst_errs", {err_ovf, err_unf}, 0);
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Store with oen==0 produces no beat; pc wrap and wrapped push
      issue(STO, 8'h00, 8'h00);
      chk("sto_oen0_valid", out_valid, 0);
      issue(JMP, 8'hFF, 8'h00);
      chk("wrap_jmp_pc", pc, 8'hFF);
      issue(NOPF, 8'h00, 8'h00);
      chk("wrap_pc", pc, 8'h00);
      chk("nopf_pulse", flag_f, 1);
      issue(LD, 8'h00, 8'h00);
      chk("nopf_pulse_end", flag_f, 0);
      issue(JMP, 8'hFF, 8'h00);
      issue(JMP, 8'h80, 8'h00);
      chk("wrap_push_pc", pc, 8'h80);
      issue(RTN, 8'h00, 8'h00);
      chk("wrap_ret_pc", pc, 8'h00);
      issue(NOPF, 8'h00, 8'h00);
      chk("wrap_ret_skip_pc", pc, 8'h01);
      chk("wrap_ret_skip_flag", flag_f, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
